// File: rtl/fifo_pkg.sv
// Shared definitions for the async FIFO read- and write-side controllers.
package fifo_pkg;

  localparam int ADDRSIZE_DEF = 4;

  // Pointer code conversions. The width argument masks off bits above the
  // pointer so that callers can pass any pointer zero-extended to 32 bits.
  function automatic logic [31:0] width_mask(input int width);
    logic [31:0] m;
    if (width >= 32) begin
      m = '1;
    end else begin
      m = (32'd1 << width) - 32'd1;
    end
    return m;
  endfunction

  function automatic logic [31:0] bin2gray(input logic [31:0] b, input int width);
    logic [31:0] bm;
    bm = b & width_mask(width);
    return bm ^ (bm >> 1);
  endfunction

  // Log-step XOR prefix from the MSB downward: bit i becomes the XOR of all
  // Gray bits at or above i.
  function automatic logic [31:0] gray2bin(input logic [31:0] g, input int width);
    logic [31:0] b;
    b = g & width_mask(width);
    b = b ^ (b >> 1);
    b = b ^ (b >> 2);
    b = b ^ (b >> 4);
    b = b ^ (b >> 8);
    b = b ^ (b >> 16);
    return b;
  endfunction

endpackage

// File: rtl/fifo_rd_arbiter_rr.sv
// Round-robin pick of one requester. The grant is combinational so the
// consumer sees it in the same cycle as FIFO rdata; only the "last granted"
// index is registered.
module rr_arbiter #(
  parameter int NREQ = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] gnt
);

  localparam int LW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [LW-1:0] last_q;
  logic [LW-1:0] last_d;
  logic [LW-1:0] idx;
  logic [LW-1:0] pick;
  logic          found;

  // Scan from the requester after the last winner, wrapping; first hit wins.
  always_comb begin
    gnt    = '0;
    last_d = last_q;
    found  = 1'b0;
    pick   = last_q;
    idx    = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = LW'((int'(last_q) + k) % NREQ);
      if (!found && req[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
    if (en && found) begin
      gnt[pick] = 1'b1;
      last_d    = pick;
    end
  end

  // Last-winner register; resets to NREQ-1 so requester 0 is served first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q <= LW'(NREQ - 1);
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/fifo_rd_arbiter.sv
// Read-domain controller of the async FIFO: read pointer, empty flag, fill
// level, and a round-robin share of the single read port.
module fifo_rd_arbiter
  import fifo_pkg::*;
#(
  parameter int ADDRSIZE = ADDRSIZE_DEF,
  parameter int NREQ     = 2
) (
  input  logic                rclk,
  input  logic                rrst,
  input  logic [ADDRSIZE:0]   rq2_wptr,
  input  logic [NREQ-1:0]     req,
  output logic [NREQ-1:0]     gnt,
  output logic [ADDRSIZE-1:0] raddr,
  output logic [ADDRSIZE:0]   rptr,
  output logic                rempty,
  output logic [ADDRSIZE:0]   rlevel
);

  localparam int PW = ADDRSIZE + 1;

  logic [PW-1:0]   rbin_q;
  logic [PW-1:0]   rbin_d;
  logic [PW-1:0]   rptr_q;
  logic [PW-1:0]   rptr_d;
  logic [PW-1:0]   rlevel_q;
  logic [PW-1:0]   rlevel_d;
  logic [PW-1:0]   wbin;
  logic            rempty_q;
  logic            rempty_d;
  logic            rinc;
  logic [NREQ-1:0] gnt_w;

  // Grants are suppressed while empty, so a read can never underflow.
  rr_arbiter #(
    .NREQ (NREQ)
  ) u_arb (
    .clk (rclk),
    .rst (rrst),
    .en  (~rempty_q),
    .req (req),
    .gnt (gnt_w)
  );

  // Next pointer, empty and level. Empty and level both look at the
  // post-read pointer so the flag sets on the edge that drains the last entry.
  always_comb begin
    rinc     = |gnt_w;
    rbin_d   = rbin_q + {{(PW-1){1'b0}}, rinc};
    rptr_d   = PW'(bin2gray(32'(rbin_d), PW));
    wbin     = PW'(gray2bin(32'(rq2_wptr), PW));
    rempty_d = (rptr_d == rq2_wptr);
    rlevel_d = wbin - rbin_d;
  end

  // Read-side state registers.
  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      rbin_q   <= '0;
      rptr_q   <= '0;
      rempty_q <= 1'b1;
      rlevel_q <= '0;
    end else begin
      rbin_q   <= rbin_d;
      rptr_q   <= rptr_d;
      rempty_q <= rempty_d;
      rlevel_q <= rlevel_d;
    end
  end

  assign gnt    = gnt_w;
  assign raddr  = rbin_q[ADDRSIZE-1:0];
  assign rptr   = rptr_q;
  assign rempty = rempty_q;
  assign rlevel = rlevel_q;

endmodule

// File: tb/tb_fifo_rd_arbiter.sv
// Directed bench for fifo_rd_arbiter with ADDRSIZE=4, NREQ=2.
module tb_fifo_rd_arbiter;

  localparam int AW = 4;
  localparam int NR = 2;
  localparam int PW = AW + 1;

  logic          rclk = 1'b0;
  logic          rrst;
  logic [PW-1:0] rq2_wptr;
  logic [NR-1:0] req;
  logic [NR-1:0] gnt;
  logic [AW-1:0] raddr;
  logic [PW-1:0] rptr;
  logic          rempty;
  logic [PW-1:0] rlevel;

  int n_checks = 0;
  int n_fail   = 0;

  fifo_rd_arbiter #(.ADDRSIZE(AW), .NREQ(NR)) dut (
    .rclk     (rclk),
    .rrst     (rrst),
    .rq2_wptr (rq2_wptr),
    .req      (req),
    .gnt      (gnt),
    .raddr    (raddr),
    .rptr     (rptr),
    .rempty   (rempty),
    .rlevel   (rlevel)
  );

  always #5 rclk = ~rclk;

  function automatic logic [PW-1:0] g(input int b);
    logic [PW-1:0] t;
    t = PW'(b);
    return t ^ (t >> 1);
  endfunction

  task automatic tick();
    @(posedge rclk);
    #1;
  endtask

  task automatic reset_dut();
    rrst = 1'b1; rq2_wptr = '0; req = '0;
    #1;
    rrst = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    n_checks++; if (rempty !== 1'b1) begin n_fail++; $display("FAIL reset_rempty got %b exp 1", rempty); end
    n_checks++; if (rptr !== 5'b00000) begin n_fail++; $display("FAIL reset_rptr got %b exp 00000", rptr); end
    n_checks++; if (raddr !== 4'd0) begin n_fail++; $display("FAIL reset_raddr got %0d exp 0", raddr); end
    n_checks++; if (rlevel !== 5'd0) begin n_fail++; $display("FAIL reset_rlevel got %0d exp 0", rlevel); end
    n_checks++; if (gnt !== 2'b00) begin n_fail++; $display("FAIL reset_gnt got %b exp 00", gnt); end
    rq2_wptr = g(3);
    req = 2'b01;
    tick();
    n_checks++; if (rempty !== 1'b1) begin n_fail++; $display("FAIL reset_hold_rempty got %b exp 1", rempty); end
    n_checks++; if (gnt !== 2'b00) begin n_fail++; $display("FAIL reset_hold_gnt got %b exp 00", gnt); end
    rq2_wptr = '0;
    req = '0;
    rrst = 1'b0;
    tick();
    tick();
    n_checks++; if (rempty !== 1'b1) begin n_fail++; $display("FAIL idle_rempty got %b exp 1", rempty); end
    n_checks++; if (rlevel !== 5'd0) begin n_fail++; $display("FAIL idle_rlevel got %0d exp 0", rlevel); end
  endtask

  task automatic test_basic();
    rq2_wptr = 5'b00010;
    req = 2'b01;
    #1;
    n_checks++; if (gnt !== 2'b00) begin n_fail++; $display("FAIL basic_gnt_when_empty got %b exp 00", gnt); end
    tick();
    n_checks++; if (rempty !== 1'b0) begin n_fail++; $display("FAIL basic_rempty_fall got %b exp 0", rempty); end
    n_checks++; if (rlevel !== 5'd3) begin n_fail++; $display("FAIL basic_rlevel got %0d exp 3", rlevel); end
    for (int i = 0; i < 3; i++) begin
      n_checks++; if (gnt !== 2'b01) begin n_fail++; $display("FAIL basic_gnt[%0d] got %b exp 01", i, gnt); end
      n_checks++; if (raddr !== 4'(i)) begin n_fail++; $display("FAIL basic_raddr[%0d] got %0d exp %0d", i, raddr, i); end
      tick();
      n_checks++; if (rlevel !== 5'(2 - i)) begin n_fail++; $display("FAIL basic_level[%0d] got %0d exp %0d", i, rlevel, 2 - i); end
    end
    n_checks++; if (rempty !== 1'b1) begin n_fail++; $display("FAIL basic_rempty_end got %b exp 1", rempty); end
    n_checks++; if (gnt !== 2'b00) begin n_fail++; $display("FAIL basic_gnt_end got %b exp 00", gnt); end
    n_checks++; if (rptr !== 5'b00010) begin n_fail++; $display("FAIL basic_rptr_end got %b exp 00010", rptr); end
    req = '0;
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_g [4];
    exp_g = '{2'b01, 2'b10, 2'b01, 2'b10};
    reset_dut();
    rq2_wptr = 5'b00110;
    req = 2'b11;
    tick();
    n_checks++; if (rlevel !== 5'd4) begin n_fail++; $display("FAIL rr_rlevel got %0d exp 4", rlevel); end
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (gnt !== exp_g[i]) begin n_fail++; $display("FAIL rr_gnt[%0d] got %b exp %b", i, gnt, exp_g[i]); end
      n_checks++; if (raddr !== 4'(i)) begin n_fail++; $display("FAIL rr_raddr[%0d] got %0d exp %0d", i, raddr, i); end
      tick();
    end
    n_checks++; if (rempty !== 1'b1) begin n_fail++; $display("FAIL rr_rempty got %b exp 1", rempty); end
    n_checks++; if (rptr !== 5'b00110) begin n_fail++; $display("FAIL rr_rptr got %b exp 00110", rptr); end
    n_checks++; if (gnt !== 2'b00) begin n_fail++; $display("FAIL rr_gnt_end got %b exp 00", gnt); end
    req = '0;
  endtask

  task automatic test_wrap();
    int ends [3];
    int rb;
    ends = '{8, 16, 20};
    rb = 0;
    reset_dut();
    req = 2'b01;
    for (int b = 0; b < 3; b++) begin
      rq2_wptr = g(ends[b]);
      tick();
      for (; rb < ends[b]; rb++) begin
        n_checks++; if (gnt !== 2'b01) begin n_fail++; $display("FAIL wrap_gnt[%0d] got %b exp 01", rb, gnt); end
        n_checks++; if (raddr !== 4'(rb)) begin n_fail++; $display("FAIL wrap_raddr[%0d] got %0d exp %0d", rb, raddr, rb % 16); end
        n_checks++; if (rptr !== g(rb)) begin n_fail++; $display("FAIL wrap_rptr[%0d] got %b exp %b", rb, rptr, g(rb)); end
        n_checks++; if (rlevel !== 5'(ends[b] - rb)) begin n_fail++; $display("FAIL wrap_level[%0d] got %0d exp %0d", rb, rlevel, ends[b] - rb); end
        if (rb == 15) begin
          n_checks++; if (rptr !== 5'b01000) begin n_fail++; $display("FAIL wrap_rptr15 got %b exp 01000", rptr); end
        end
        if (rb == 16) begin
          n_checks++; if (rptr !== 5'b11000 || raddr !== 4'd0) begin n_fail++; $display("FAIL wrap_rptr16 got %b/%0d exp 11000/0", rptr, raddr); end
        end
        tick();
      end
      n_checks++; if (rempty !== 1'b1) begin n_fail++; $display("FAIL wrap_rempty[%0d] got %b exp 1", b, rempty); end
      n_checks++; if (rptr !== g(ends[b])) begin n_fail++; $display("FAIL wrap_rptr_end[%0d] got %b exp %b", b, rptr, g(ends[b])); end
    end
    n_checks++; if (rptr !== 5'b11110) begin n_fail++; $display("FAIL wrap_rptr20 got %b exp 11110", rptr); end
    n_checks++; if (raddr !== 4'd4) begin n_fail++; $display("FAIL wrap_raddr20 got %0d exp 4", raddr); end
  endtask

  task automatic test_simultaneous();
    rq2_wptr = 5'b11111;
    req = 2'b01;
    tick();
    n_checks++; if (rempty !== 1'b0 || rlevel !== 5'd1) begin n_fail++; $display("FAIL sim_pre got rempty=%b level=%0d exp 0/1", rempty, rlevel); end
    rq2_wptr = 5'b11101;
    #1;
    n_checks++; if (gnt !== 2'b01) begin n_fail++; $display("FAIL sim_gnt got %b exp 01", gnt); end
    tick();
    n_checks++; if (rempty !== 1'b0) begin n_fail++; $display("FAIL sim_rempty_kept got %b exp 0", rempty); end
    n_checks++; if (rlevel !== 5'd1) begin n_fail++; $display("FAIL sim_rlevel got %0d exp 1", rlevel); end
    n_checks++; if (raddr !== 4'd5) begin n_fail++; $display("FAIL sim_raddr got %0d exp 5", raddr); end
    tick();
    n_checks++; if (rempty !== 1'b1) begin n_fail++; $display("FAIL sim_rempty_end got %b exp 1", rempty); end
    rq2_wptr = 5'b10100;
    req = 2'b11;
    tick();
    n_checks++; if (gnt !== 2'b10) begin n_fail++; $display("FAIL drop_first got %b exp 10", gnt); end
    tick();
    n_checks++; if (gnt !== 2'b01) begin n_fail++; $display("FAIL drop_pri0 got %b exp 01", gnt); end
    req = 2'b10;
    #1;
    n_checks++; if (gnt !== 2'b10) begin n_fail++; $display("FAIL drop_next got %b exp 10", gnt); end
    tick();
    n_checks++; if (rempty !== 1'b1) begin n_fail++; $display("FAIL drop_rempty got %b exp 1", rempty); end
    rq2_wptr = 5'b10111;
    req = 2'b01;
    tick();
    n_checks++; if (gnt !== 2'b01) begin n_fail++; $display("FAIL b2b_0 got %b exp 01", gnt); end
    tick();
    n_checks++; if (gnt !== 2'b01) begin n_fail++; $display("FAIL b2b_1 got %b exp 01", gnt); end
    tick();
    n_checks++; if (rempty !== 1'b1 || gnt !== 2'b00) begin n_fail++; $display("FAIL b2b_end got rempty=%b gnt=%b exp 1/00", rempty, gnt); end
    req = '0;
  endtask

  task automatic test_full();
    reset_dut();
    rq2_wptr = 5'b11000;
    req = 2'b01;
    tick();
    n_checks++; if (rlevel !== 5'b10000) begin n_fail++; $display("FAIL full_rlevel got %b exp 10000", rlevel); end
    for (int i = 0; i < 16; i++) begin
      n_checks++; if (gnt !== 2'b01) begin n_fail++; $display("FAIL full_gnt[%0d] got %b exp 01", i, gnt); end
      n_checks++; if (rlevel !== 5'(16 - i)) begin n_fail++; $display("FAIL full_level[%0d] got %0d exp %0d", i, rlevel, 16 - i); end
      tick();
    end
    n_checks++; if (rempty !== 1'b1) begin n_fail++; $display("FAIL full_rempty got %b exp 1", rempty); end
    n_checks++; if (rlevel !== 5'd0) begin n_fail++; $display("FAIL full_rlevel_end got %0d exp 0", rlevel); end
    n_checks++; if (rptr !== 5'b11000) begin n_fail++; $display("FAIL full_rptr got %b exp 11000", rptr); end
    req = '0;
  endtask

  task automatic test_reset_mid();
    reset_dut();
    rq2_wptr = 5'b00111;
    tick();
    n_checks++; if (rlevel !== 5'd5 || rempty !== 1'b0) begin n_fail++; $display("FAIL mid_pre got level=%0d rempty=%b exp 5/0", rlevel, rempty); end
    req = 2'b10;
    #1;
    n_checks++; if (gnt !== 2'b10) begin n_fail++; $display("FAIL mid_gnt_pre got %b exp 10", gnt); end
    #2;
    rrst = 1'b1;
    #1;
    n_checks++; if (gnt !== 2'b00) begin n_fail++; $display("FAIL mid_gnt got %b exp 00", gnt); end
    n_checks++; if (rempty !== 1'b1) begin n_fail++; $display("FAIL mid_rempty got %b exp 1", rempty); end
    n_checks++; if (rlevel !== 5'd0 || rptr !== 5'd0 || raddr !== 4'd0) begin n_fail++; $display("FAIL mid_regs got level=%0d rptr=%b raddr=%0d exp 0", rlevel, rptr, raddr); end
    rq2_wptr = '0;
    #1;
    rrst = 1'b0;
    tick();
    tick();
    n_checks++; if (gnt !== 2'b00 || rempty !== 1'b1) begin n_fail++; $display("FAIL mid_idle got gnt=%b rempty=%b exp 00/1", gnt, rempty); end
    rq2_wptr = 5'b00001;
    #1;
    n_checks++; if (gnt !== 2'b00) begin n_fail++; $display("FAIL mid_gnt_same got %b exp 00", gnt); end
    tick();
    n_checks++; if (gnt !== 2'b10) begin n_fail++; $display("FAIL mid_first_gnt got %b exp 10", gnt); end
    req = 2'b11;
    #1;
    n_checks++; if (gnt !== 2'b01) begin n_fail++; $display("FAIL mid_priority got %b exp 01", gnt); end
    req = '0;
  endtask

  initial begin
    rrst = 1'b1;
    rq2_wptr = '0;
    req = '0;
    test_reset();
    test_basic();
    test_round_robin();
    test_wrap();
    test_simultaneous();
    test_full();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_rd_arbiter.md
Name: fifo_rd_arbiter

Overview:
- Read-domain controller for the async FIFO.
- Owns the read pointer and the empty flag, and converts the synchronized Gray write pointer into a fill level.
- Round-robin arbitrates one FIFO read port among NREQ consumers.
- Sits between the read-side two-flop write-pointer synchronizer output (rq2_wptr) and the FIFO memory read address. It drives rptr back to the write-side synchronizer.

Parameters:
- ADDRSIZE, 4, FIFO address width; depth = 2**ADDRSIZE; pointers are ADDRSIZE+1 bits.
- NREQ, 2, number of read requesters sharing the port (2..8).

Ports:
- rclk  input  1  read-domain clock; the only clock.
- rrst  input  1  reset, asynchronous, active-high.
- rq2_wptr  input  ADDRSIZE+1  write pointer (Gray), already synchronized into rclk.
- req  input  NREQ  per-consumer read request, level; held until granted.
- gnt  output  NREQ  one-hot read grant; FIFO rdata is valid in the same cycle.
- raddr  output  ADDRSIZE  memory read address = rbin[ADDRSIZE-1:0].
- rptr  output  ADDRSIZE+1  registered Gray read pointer, to the w-side synchronizer.
- rempty  output  1  registered empty flag.
- rlevel  output  ADDRSIZE+1  registered entry count seen by the read side, 0..2**ADDRSIZE.

Behaviour:
- Reset values, applied asynchronously on rrst=1:
  - rbin=0, rptr=0, rempty=1, rlevel=0.
  - Round-robin pointer last=NREQ-1, so req[0] has top priority first.
  - gnt=0. gnt is combinational from rempty, so it drops in the same instant.
- Grant (combinational):
  - If rempty=0 and |req, gnt = one-hot of the first set req bit scanning from (last+1) mod NREQ upward with wrap.
  - Otherwise gnt=0.
  - rinc = |gnt. Reads are never issued when empty, so underflow is impossible.
- Pointer update on each rclk edge:
  - rbinnext = rbin + rinc, modulo 2**(ADDRSIZE+1).
  - rgraynext = (rbinnext>>1) ^ rbinnext.
  - rbin <= rbinnext; rptr <= rgraynext.
  - If rinc, last <= index of gnt.
- Empty:
  - rempty <= (rgraynext == rq2_wptr).
  - Empty is asserted on the edge that consumes the last entry.
  - Empty is deasserted one rclk after rq2_wptr changes.
  - There is no additional synchronizer latency beyond rq2_wptr.
- Level:
  - wbin = Gray-to-binary of rq2_wptr, combinational XOR prefix.
  - rlevel <= wbin - rbinnext, ADDRSIZE+1 bits, modulo arithmetic.
  - Full depth reads as 2**ADDRSIZE, e.g. 16 = 10000b.
  - rlevel is pessimistic-by-latency only; it never overstates the entries available.
- Wrap-around: raddr wraps 2**ADDRSIZE-1 -> 0 while the rbin MSB toggles. Gray compare and level stay correct across the 2**(ADDRSIZE+1)-1 -> 0 wrap.
- Simultaneous events:
  - A write arriving (rq2_wptr change) in the same cycle as the final read leaves rempty=0 if rgraynext != the new rq2_wptr.
  - A request dropping in the same cycle it would be granted is legal; the grant goes to the next eligible requester.
- Handshake:
  - A consumer samples rdata when its gnt bit is 1, exactly one entry per grant cycle.
  - A consumer holding req receives back-to-back grants only if no other req is set.
- Reset mid-operation: all state returns to reset values immediately, and pending requests are not remembered. After reset release, the first grant can occur only after rq2_wptr differs from 0 and rempty has cleared.

Decomposition:
- Shared package fifo_pkg:
  - default ADDRSIZE.
  - functions bin2gray and gray2bin, parameterized by width, also used by the write-side controller.
- Sub-module rr_arbiter (NREQ): combinational one-hot pick from req, enable and last, plus the registered last pointer.
- This top block: pointer, empty, level.

Test Plan:
All scenarios use ADDRSIZE=4 and NREQ=2.
1. Assert rrst mid-clock -> immediately rempty=1, rptr=00000, raddr=0, rlevel=0, gnt=00.
2. rq2_wptr steps 00000->00010 (3 entries), req=01 held:
   - rempty falls after 1 edge and rlevel=3.
   - gnt=01 for 3 cycles with raddr 0,1,2.
   - rlevel then goes 2,1,0; rempty=1 after the 3rd read; gnt=00 afterwards.
3. 4 entries available, req=11 held -> gnt sequence 01,10,01,10, then empty, rptr=00110.
4. Read 20 entries in batches with writer pointer advancing:
   - raddr wraps 15->0 and rptr goes 01000 (bin 15) -> 11000 (bin 16).
   - rempty asserts exactly when rptr equals rq2_wptr, e.g. both 11110 (bin 20).
5. Full FIFO, rq2_wptr=11000 (bin 16) with rbin=0 -> rlevel=10000; 16 grants drain it to rempty=1.
6. rrst pulsed while rlevel=5 and req=10 -> gnt=00 in the same cycle. After release, the first gnt goes to req[1] only after rq2_wptr changes again, and priority starts from req[0].
